tx_scramble_encode: RTL and testbench
=====================================

# tx_scramble_encode

Parametrised transmit front end for the 802.11a chain. It builds the DATA-field bit stream (16-bit SERVICE, PSDU bits, 6 tail bits, `n_pad` pad bits) and scrambles it with x^7+x^4+1. It then convolutionally encodes the stream (K=7, g0=133₈, g1=171₈) with selectable puncturing to rate 1/2, 2/3 or 3/4. It sits between the bit-serial PSDU source and the interleaver, and emits one coded bit per cycle.

## Interface
- `LEN_W`, 12, width of `n_data` (PSDU bit count).
- `N_PAD_W`, 6, width of `n_pad`.
- `SEED_DEFAULT`, 7'b1111111, scrambler seed used when `seed` is all-zero.

- `Clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  frame start strobe, sampled in IDLE only.
- `seed`  in  7  scrambler initial state, sampled with `start`.
- `rate`  in  2  00=1/2, 01=2/3, 10=3/4, 11 treated as 1/2; sampled with `start`.
- `n_data`  in  LEN_W  PSDU bits, sampled with `start`.
- `n_pad`  in  N_PAD_W  pad bits, sampled with `start`.
- `data_in`  in  1  PSDU bit.
- `in_valid`  in  1  `data_in` valid.
- `in_ready`  out  1  block consumes `data_in` this cycle if `in_valid`.
- `data_out`  out  1  coded bit.
- `out_valid`  out  1  `data_out` valid.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the last coded bit.

## Operation
- States: IDLE → SERVICE (16 zero bits) → DATA (`n_data` bits from input, skipped if 0) → TAIL (6 bits) → PAD (`n_pad` bits, skipped if 0) → FIN → IDLE.
- Source bit count is n_src = 22 + n_data + n_pad. Phase counters run over LEN_W+1 bits.
- Scrambler state s[7:1] is loaded from `seed` at `start`. Each source bit computes fb = s7 ^ s4, shifts in fb at s1, and outputs bit ^ fb.
- The scrambler advances on every source bit, including TAIL. TAIL bits enter the encoder as 0, not scrambled.
- Encoder shift register clears at `start`.
  - A = XOR of current bit and delays 2, 3, 5, 6.
  - B = XOR of current bit and delays 1, 2, 3, 6.
- A puncture phase counter clears at `start` and advances once per source bit, modulo 1, 2 or 3.
  - 1/2: emit A then B.
  - 2/3: phase 0 emits A, B; phase 1 emits A.
  - 3/4: phase 0 emits A, B; phase 1 emits A; phase 2 emits B.
- Slot: one source bit occupies 1 or 2 cycles, equal to its emitted-bit count.
- In DATA, `in_ready` is 1 only on a slot's first cycle. If `in_valid` is 0 then, the slot stalls: no bit is consumed, `out_valid` is 0 the following cycle, and the block retries.
- `start` while `busy` is ignored.
- A short final puncture pattern emits only the positions reached; there is no fill.

## Timing
- Reset values: all outputs 0, state IDLE, all registers cleared.
- `start` accepted at cycle t: `busy`=1 from t+1, and the first SERVICE slot begins at t+1.
- A slot beginning at cycle c drives its first coded bit at c+1 and its second, if any, at c+2. Output is registered with no combinational input-to-output path.
- With no stalls, `out_valid` is continuous from the first coded bit to the last.
- Total coded bits:
  - 1/2: 2·n_src.
  - 2/3: ⌈3·n_src/2⌉.
  - 3/4: 4·n_src/3 rounded per the pattern.
- `done`=1 the cycle after the last `out_valid`. `busy` falls on that same cycle, and `start` is accepted again on the next cycle.
- `reset` mid-frame aborts the frame on the next edge. It emits no `done` and drops partial output.

## Configuration
- `TX_PUNCTURE_EN` defined: puncturing logic present, and `rate` behaves as above.
- `TX_PUNCTURE_EN` not defined: `rate` is ignored, the block is always rate 1/2, and the phase counter is removed.

## Test plan
- Rate 1/2, `seed`=7'h7F, n_data=0, n_pad=0 → 44 coded bits, first 14 = 00000000111001, then `done` pulses once.
- Rate 1/2, n_data=24 random bits with `in_valid` always 1 → `out_valid` continuous for 92 cycles; bitstream matches the golden model (Out_v.txt).
- Rate 3/4, n_data=24, n_pad=8 (n_src=54) → exactly 72 coded bits; 2/3 with the same frame → 81 bits.
- `in_valid` deasserted for 5 cycles mid-DATA → output gaps of exactly 5 cycles; bitstream identical to the no-stall run.
- `seed`=0 → output identical to the `seed`=7'h7F run; `start` pulsed while `busy` → no effect.
- `reset` asserted mid-DATA → next cycle all outputs 0, IDLE; a following frame is bit-exact with a fresh-reset run.

Source files
------------

// File: rtl/tx_scramble_encode_if.sv
// Frame-control, PSDU input and coded-output signals of tx_scramble_encode.
// master = frame source / coded-bit sink, slave = the encoder.
interface tx_scramble_encode_if #(
    parameter int LEN_W   = 12,
    parameter int N_PAD_W = 6
);
    logic               start;
    logic [6:0]         seed;
    logic [1:0]         rate;
    logic [LEN_W-1:0]   n_data;
    logic [N_PAD_W-1:0] n_pad;
    logic               data_in;
    logic               in_valid;
    logic               in_ready;
    logic               data_out;
    logic               out_valid;
    logic               busy;
    logic               done;

    modport master (
        output start, seed, rate, n_data, n_pad, data_in, in_valid,
        input  in_ready, data_out, out_valid, busy, done
    );

    modport slave (
        input  start, seed, rate, n_data, n_pad, data_in, in_valid,
        output in_ready, data_out, out_valid, busy, done
    );
endinterface

// File: rtl/tx_scramble_encode.sv
// 802.11a DATA-field builder: x^7+x^4+1 scrambler feeding a K=7 (133/171 octal) encoder.
// Define TX_PUNCTURE_EN to enable 2/3 and 3/4 puncturing; otherwise the block is fixed at rate 1/2.
module tx_scramble_encode #(
    parameter int         LEN_W        = 12,
    parameter int         N_PAD_W      = 6,
    parameter logic [6:0] SEED_DEFAULT = 7'b1111111
) (
    input  logic                Clk,
    input  logic                reset,
    tx_scramble_encode_if.slave bus
);
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVICE,
        S_DATA,
        S_TAIL,
        S_PAD,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   n_data_q, n_data_d;
    logic [N_PAD_W-1:0] n_pad_q, n_pad_d;
    logic [7:1]         scr_q, scr_d;
    logic [6:1]         enc_q, enc_d;
    logic               second_q, second_d;
    logic               b_hold_q, b_hold_d;
    logic               data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;
`ifdef TX_PUNCTURE_EN
    logic [1:0]         rate_q, rate_d;
    logic [1:0]         phase_q, phase_d;
`else
    logic               unused_rate;
    assign unused_rate = ^bus.rate;
`endif

    logic               fb, enc_in, coded_a, coded_b;
    logic               two_bits, first_bit, advance;
    logic [CNT_W-1:0]   phase_len;
    state_e             next_region;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_data_d    = n_data_q;
        n_pad_d     = n_pad_q;
        scr_d       = scr_q;
        enc_d       = enc_q;
        second_d    = second_q;
        b_hold_d    = b_hold_q;
`ifdef TX_PUNCTURE_EN
        rate_d      = rate_q;
        phase_d     = phase_q;
`endif
        data_out_d  = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        advance     = 1'b0;

        fb      = scr_q[7] ^ scr_q[4];
        enc_in  = (state_q == S_TAIL) ? 1'b0 : (((state_q == S_DATA) && bus.data_in) ^ fb);
        coded_a = enc_in ^ enc_q[2] ^ enc_q[3] ^ enc_q[5] ^ enc_q[6];
        coded_b = enc_in ^ enc_q[1] ^ enc_q[2] ^ enc_q[3] ^ enc_q[6];

        two_bits  = 1'b1;
        first_bit = coded_a;
`ifdef TX_PUNCTURE_EN
        case (rate_q)
            2'b01: two_bits = (phase_q == 2'd0);
            2'b10: begin
                two_bits  = (phase_q == 2'd0);
                first_bit = (phase_q == 2'd2) ? coded_b : coded_a;
            end
            default: ;
        endcase
`endif

        case (state_q)
            S_SERVICE: begin
                phase_len   = CNT_W'(16);
                next_region = (n_data_q != '0) ? S_DATA : S_TAIL;
            end
            S_DATA: begin
                phase_len   = CNT_W'(n_data_q);
                next_region = S_TAIL;
            end
            S_TAIL: begin
                phase_len   = CNT_W'(6);
                next_region = (n_pad_q != '0) ? S_PAD : S_FIN;
            end
            default: begin
                phase_len   = CNT_W'(n_pad_q);
                next_region = S_FIN;
            end
        endcase

        if (state_q == S_IDLE) begin
            // The cycle that shows done is still IDLE; a new frame starts the cycle after.
            if (bus.start && !done_q) begin
                state_d  = S_SERVICE;
                cnt_d    = '0;
                n_data_d = bus.n_data;
                n_pad_d  = bus.n_pad;
                scr_d    = (bus.seed == 7'd0) ? SEED_DEFAULT : bus.seed;
                enc_d    = '0;
                second_d = 1'b0;
`ifdef TX_PUNCTURE_EN
                rate_d   = bus.rate;
                phase_d  = 2'd0;
`endif
            end
        end else if (state_q == S_FIN) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end else if (second_q) begin
            data_out_d  = b_hold_q;
            out_valid_d = 1'b1;
            second_d    = 1'b0;
            advance     = 1'b1;
        end else if (state_q != S_DATA || bus.in_valid) begin
            data_out_d  = first_bit;
            out_valid_d = 1'b1;
            scr_d       = {scr_q[6:1], fb};
            enc_d       = {enc_q[5:1], enc_in};
`ifdef TX_PUNCTURE_EN
            case (rate_q)
                2'b01:   phase_d = (phase_q == 2'd0) ? 2'd1 : 2'd0;
                2'b10:   phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                default: phase_d = 2'd0;
            endcase
`endif
            if (two_bits) begin
                second_d = 1'b1;
                b_hold_d = coded_b;
            end else begin
                advance = 1'b1;
            end
        end

        if (advance) begin
            if (cnt_q + CNT_W'(1) == phase_len) begin
                state_d = next_region;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_DATA) && !second_d;
    end

    always_ff @(posedge Clk) begin
        // NOTE: every register is cleared, not just the FSM, so an aborted frame leaves no residue.
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_data_q    <= '0;
            n_pad_q     <= '0;
            scr_q       <= '0;
            enc_q       <= '0;
            second_q    <= 1'b0;
            b_hold_q    <= 1'b0;
            data_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef TX_PUNCTURE_EN
            rate_q      <= 2'd0;
            phase_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_data_q    <= n_data_d;
            n_pad_q     <= n_pad_d;
            scr_q       <= scr_d;
            enc_q       <= enc_d;
            second_q    <= second_d;
            b_hold_q    <= b_hold_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
`ifdef TX_PUNCTURE_EN
            rate_q      <= rate_d;
            phase_q     <= phase_d;
`endif
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_tx_scramble_encode.sv
// Directed bench for tx_scramble_encode: frame timing, coded bitstreams, puncturing, stalls and aborts.
module tb_tx_scramble_encode;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tx_scramble_encode_if #(.LEN_W(12), .N_PAD_W(6)) bus ();

    tx_scramble_encode #(.LEN_W(12), .N_PAD_W(6), .SEED_DEFAULT(7'b1111111)) dut (
        .Clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef TX_PUNCTURE_EN
    localparam int EXP_34 = 72;
    localparam int EXP_23 = 81;
`else
    localparam int EXP_34 = 108;
    localparam int EXP_23 = 108;
`endif

    int   checks = 0;
    int   passed = 0;
    logic psdu [64];
    logic exp_q [$];
    logic got_q [$];
    logic ref12_q [$];

    int   valid_cnt, gap_cnt, first_r, last_r, done_r, done_cnt;
    logic busy_r1, busy_at_done;

    // Independent reference: scrambler as a bit array, encoder via octal generator masks,
    // puncturing via keep-patterns indexed by source-bit position.
    task automatic build_expected(input logic [1:0] rate, input logic [6:0] seed,
                                  input int n_data, input int n_pad);
        logic       sc [1:7];
        logic [6:0] v;
        logic       fb, src, x;
        logic [2:0] keep_a, keep_b;
        int         period, n_src, p;
        logic [1:0] eff;
`ifdef TX_PUNCTURE_EN
        eff = rate;
`else
        eff = 2'b00;
`endif
        case (eff)
            2'b01:   begin period = 2; keep_a = 3'b011; keep_b = 3'b001; end
            2'b10:   begin period = 3; keep_a = 3'b011; keep_b = 3'b101; end
            default: begin period = 1; keep_a = 3'b001; keep_b = 3'b001; end
        endcase
        exp_q.delete();
        for (int k = 1; k <= 7; k++) sc[k] = (seed == 7'd0) ? 1'b1 : seed[k-1];
        v = '0;
        n_src = 22 + n_data + n_pad;
        for (int i = 0; i < n_src; i++) begin
            if (i >= 16 && i < 16 + n_data) src = psdu[i-16];
            else src = 1'b0;
            fb = sc[7] ^ sc[4];
            for (int k = 7; k >= 2; k--) sc[k] = sc[k-1];
            sc[1] = fb;
            x = (i >= 16 + n_data && i < 22 + n_data) ? 1'b0 : (src ^ fb);
            v = {x, v[6:1]};
            p = i % period;
            if (keep_a[p]) exp_q.push_back(^(v & 7'o133));
            if (keep_b[p]) exp_q.push_back(^(v & 7'o171));
        end
    endtask

    function automatic int stream_diff();
        int d = 0;
        if (got_q.size() != exp_q.size()) d++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    // Drives one frame and records what comes out. Inputs change and outputs are sampled on negedges.
    task automatic run_frame(input logic [1:0] rate, input logic [6:0] seed, input int n_data,
                             input int n_pad, input int stall_at, input int spur_at);
        int idx = 0;
        int stall_left = 5;
        got_q.delete();
        valid_cnt = 0; gap_cnt = 0; first_r = -1; last_r = -1; done_r = -1; done_cnt = 0;
        busy_r1 = 1'b0; busy_at_done = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.seed = seed; bus.rate = rate;
        bus.n_data = 12'(n_data); bus.n_pad = 6'(n_pad); bus.in_valid = 1'b1;
        for (int r = 1; r <= 3000; r++) begin
            @(negedge clk);
            if (r == 1) begin
                bus.start = 1'b0; bus.seed = 7'h2A; bus.rate = ~rate;
                bus.n_data = 12'd5; bus.n_pad = 6'd3;
                busy_r1 = bus.busy;
            end
            if (r == spur_at) begin
                bus.start = 1'b1; bus.seed = 7'h55; bus.rate = 2'b10; bus.n_data = 12'd3;
            end else if (r == spur_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.out_valid) begin
                got_q.push_back(bus.data_out);
                valid_cnt++;
                if (first_r < 0) first_r = r;
                last_r = r;
            end else if (first_r >= 0 && done_r < 0 && !bus.done) begin
                gap_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_r < 0) begin
                    done_r = r;
                    busy_at_done = bus.busy;
                end
            end
            if (done_r >= 0 && r >= done_r + 3) break;
            if (bus.in_ready && stall_at >= 0 && idx == stall_at && stall_left > 0) begin
                bus.in_valid = 1'b0;
                stall_left--;
            end else begin
                bus.in_valid = 1'b1;
                if (bus.in_ready && idx < 64) begin
                    bus.data_in = psdu[idx];
                    idx++;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.data_out !== 1'b0) $display("FAIL reset_data_out: got %b want 0", bus.data_out); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_null_frame();
        logic [13:0] first14 = '0;
        run_frame(2'b00, 7'h7F, 0, 0, -1, -1);
        build_expected(2'b00, 7'h7F, 0, 0);
        for (int i = 0; i < 14 && i < got_q.size(); i++) first14 = {first14[12:0], got_q[i]};
        checks++; if (valid_cnt !== 44) $display("FAIL null_count: got %0d want 44", valid_cnt); else passed++;
        checks++; if (first14 !== 14'b00000000111001) $display("FAIL null_first14: got %b want 00000000111001", first14); else passed++;
        checks++; if (stream_diff() !== 0) $display("FAIL null_stream: %0d bit errors vs model", stream_diff()); else passed++;
        checks++; if (busy_r1 !== 1'b1) $display("FAIL null_busy_t1: got %b want 1", busy_r1); else passed++;
        checks++; if (first_r !== 2) $display("FAIL null_first_bit_cycle: got %0d want 2", first_r); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL null_done_once: got %0d want 1", done_cnt); else passed++;
        checks++; if (done_r !== last_r + 1) $display("FAIL null_done_timing: got %0d want %0d", done_r, last_r + 1); else passed++;
        checks++; if (busy_at_done !== 1'b0) $display("FAIL null_busy_at_done: got %b want 0", busy_at_done); else passed++;
    endtask

    task automatic test_rate12_data();
        for (int i = 0; i < 64; i++) psdu[i] = 1'($urandom);
        run_frame(2'b00, 7'h7F, 24, 0, -1, -1);
        build_expected(2'b00, 7'h7F, 24, 0);
        ref12_q = got_q;
        checks++; if (valid_cnt !== 92) $display("FAIL r12_count: got %0d want 92", valid_cnt); else passed++;
        checks++; if (last_r - first_r + 1 !== 92) $display("FAIL r12_continuous: span %0d want 92", last_r - first_r + 1); else passed++;
        checks++; if (stream_diff() !== 0) $display("FAIL r12_stream: %0d bit errors vs model", stream_diff()); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL r12_done_once: got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_puncture();
        run_frame(2'b10, 7'h7F, 24, 8, -1, -1);
        build_expected(2'b10, 7'h7F, 24, 8);
        checks++; if (valid_cnt !== EXP_34) $display("FAIL r34_count: got %0d want %0d", valid_cnt, EXP_34); else passed++;
        checks++; if (stream_diff() !== 0) $display("FAIL r34_stream: %0d bit errors vs model", stream_diff()); else passed++;
        checks++; if (gap_cnt !== 0) $display("FAIL r34_gaps: got %0d want 0", gap_cnt); else passed++;
        run_frame(2'b01, 7'h7F, 24, 8, -1, -1);
        build_expected(2'b01, 7'h7F, 24, 8);
        checks++; if (valid_cnt !== EXP_23) $display("FAIL r23_count: got %0d want %0d", valid_cnt, EXP_23); else passed++;
        checks++; if (stream_diff() !== 0) $display("FAIL r23_stream: %0d bit errors vs model", stream_diff()); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL r23_done_once: got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_stall();
        run_frame(2'b00, 7'h7F, 24, 0, 10, -1);
        exp_q = ref12_q;
        checks++; if (gap_cnt !== 5) $display("FAIL stall_gap: got %0d want 5", gap_cnt); else passed++;
        checks++; if (stream_diff() !== 0) $display("FAIL stall_stream: %0d bit errors vs no-stall run", stream_diff()); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL stall_done_once: got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_seed_zero();
        run_frame(2'b00, 7'h00, 24, 0, -1, -1);
        exp_q = ref12_q;
        checks++; if (stream_diff() !== 0) $display("FAIL seed0_stream: %0d bit errors vs seed 7F run", stream_diff()); else passed++;
        checks++; if (valid_cnt !== 92) $display("FAIL seed0_count: got %0d want 92", valid_cnt); else passed++;
    endtask

    task automatic test_start_while_busy();
        run_frame(2'b00, 7'h7F, 24, 0, -1, 40);
        exp_q = ref12_q;
        checks++; if (stream_diff() !== 0) $display("FAIL busy_start_stream: %0d bit errors", stream_diff()); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL busy_start_done_once: got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int idx = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.seed = 7'h7F; bus.rate = 2'b00;
        bus.n_data = 12'd24; bus.n_pad = 6'd0; bus.in_valid = 1'b1;
        for (int r = 1; r <= 40; r++) begin
            @(negedge clk);
            if (r == 1) bus.start = 1'b0;
            if (bus.in_ready && idx < 64) begin
                bus.data_in = psdu[idx];
                idx++;
            end
        end
        checks++; if (idx !== 4) $display("FAIL abort_data_consumed: got %0d want 4", idx); else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus.out_valid, bus.data_out, bus.busy, bus.done, bus.in_ready} !== 5'b0)
            $display("FAIL abort_outputs: got %b want 00000",
                     {bus.out_valid, bus.data_out, bus.busy, bus.done, bus.in_ready});
        else passed++;
        run_frame(2'b00, 7'h7F, 24, 0, -1, -1);
        exp_q = ref12_q;
        checks++; if (stream_diff() !== 0) $display("FAIL abort_next_stream: %0d bit errors vs fresh run", stream_diff()); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL abort_next_done_once: got %0d want 1", done_cnt); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.seed = '0; bus.rate = '0; bus.n_data = '0; bus.n_pad = '0;
        bus.data_in = 1'b0; bus.in_valid = 1'b0;
        for (int i = 0; i < 64; i++) psdu[i] = 1'b0;
        test_reset();
        test_null_frame();
        test_rate12_data();
        test_puncture();
        test_stall();
        test_seed_zero();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
